uart_tx_fifo: RTL and testbench

//   UART transmitter with a small input FIFO. Serialises bytes as 8N1 frames:
//   one start bit (0), eight data bits LSB first, one stop bit (1).

---
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter (start, 8 data bits LSB first, stop) fed by a small FIFO.
// Frames go out back to back while the FIFO holds data; o_tx is driven straight from a flop.
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ = 10000000,
   parameter int unsigned BAUD     = 9600,
   parameter int unsigned DEPTH    = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [7:0]             i_data,
   input  logic                   i_valid,
   output logic                   o_ready,
   output logic                   o_tx,
   output logic                   o_busy,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;
   localparam int unsigned PTR_W        = $clog2(DEPTH);
   localparam int unsigned CW           = PTR_W + 1;
   localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [2:0]       r_bit, w_bit_nxt;
   logic [7:0]       r_shift, w_shift_nxt;
   logic             r_tx, w_tx_nxt;
   logic             w_full, w_empty, w_push, w_pop;

   assign w_full  = (r_count == FULL_CNT);
   assign w_empty = (r_count == '0);
   // Fullness is judged before this edge's pop, so a pop never frees room for a same-edge push.
   assign w_push  = i_valid && !w_full;

   assign o_ready = !w_full;
   assign o_tx    = r_tx;
   assign o_busy  = (r_state != S_IDLE);
   assign o_count = r_count;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_tx_nxt    = r_tx;
      w_pop       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tx_nxt = 1'b1;
            if (!w_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = r_mem[r_rd_ptr];
               w_tx_nxt    = 1'b0;
               w_cnt_nxt   = BIT_LOAD;
               w_bit_nxt   = '0;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (r_cnt == '0) begin
               w_tx_nxt    = r_shift[0];
               w_cnt_nxt   = BIT_LOAD;
               w_bit_nxt   = '0;
               w_state_nxt = S_DATA;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (r_cnt == '0) begin
               w_cnt_nxt = BIT_LOAD;
               if (r_bit == 3'd7) begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt   = r_bit + 3'd1;
                  w_shift_nxt = {1'b0, r_shift[7:1]};
                  w_tx_nxt    = r_shift[1];
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (r_cnt == '0) begin
               if (!w_empty) begin
                  w_pop       = 1'b1;
                  w_shift_nxt = r_mem[r_rd_ptr];
                  w_tx_nxt    = 1'b0;
                  w_cnt_nxt   = BIT_LOAD;
                  w_bit_nxt   = '0;
                  w_state_nxt = S_START;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         default: begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed stimulus, expected bytes queued at push,
// serial-line monitor decodes each frame and checks it against the queue.
module tb_uart_tx_fifo;

   localparam int CPB = 16;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       ready, tx, busy;
   logic [2:0] count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo #(.CLK_FREQ(1600), .BAUD(100), .DEPTH(4)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (data),
      .i_valid (valid),
      .o_ready (ready),
      .o_tx    (tx),
      .o_busy  (busy),
      .o_count (count)
   );

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s timed out (cycle %0d)", name, cyc);
   endtask

   // Receiver: samples the middle of each bit, frame begins at the first low seen while idle.
   logic       m_act = 1'b0;
   int         m_cnt = 0;
   logic [9:0] m_bits = '0;
   always @(negedge clk) begin
      if (rst) begin
         m_act = 1'b0;
      end else if (!m_act) begin
         if (!tx) begin
            m_act = 1'b1;
            m_cnt = 0;
         end
      end else begin
         m_cnt++;
         if (m_cnt % CPB == CPB / 2) m_bits[m_cnt / CPB] = tx;
         if (m_cnt == 9 * CPB + CPB / 2) begin
            m_act = 1'b0;
            chk("rx_start_bit", int'(m_bits[0]), 0);
            chk("rx_stop_bit", int'(m_bits[9]), 1);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL rx_unexpected_frame actual=%0d expected=none", m_bits[8:1]);
            end else begin
               chk("rx_data", int'(m_bits[8:1]), int'(exp_q.pop_front()));
            end
         end
      end
   end

   // Enter at a negedge; hold i_valid until the byte is taken; return at the next negedge.
   task automatic hold_push(input logic [7:0] b, output int acc);
      acc   = -1;
      data  = b;
      valid = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (ready) begin
            @(posedge clk);
            acc = cyc;
            exp_q.push_back(b);
            @(negedge clk);
            return;
         end
         @(negedge clk);
      end
      timeout("hold_push");
   endtask

   task automatic goto_after(input int edge_no);
      while (cyc < edge_no + 1) @(negedge clk);
   endtask

   task automatic wait_idle(input int budget);
      for (int n = 0; n < budget; n++) begin
         if (!busy && count == 3'd0) return;
         @(negedge clk);
      end
      timeout("wait_idle");
   endtask

   initial begin
      int         e;
      int         a[6];
      int         lows;
      logic [9:0] pat;

      repeat (3) @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_ready", int'(ready), 1);
      rst = 1'b0;
      @(negedge clk);

      // 1: single 0x55 frame, exact bit timing
      hold_push(8'h55, e);
      valid = 1'b0;
      chk("t1_count_after_push", int'(count), 1);
      chk("t1_tx_before_pop", int'(tx), 1);
      @(negedge clk);
      chk("t1_count_after_pop", int'(count), 0);
      pat = {1'b1, 8'h55, 1'b0};
      for (int i = 0; i < 10 * CPB; i++) begin
         chk($sformatf("t1_bit%0d_cyc%0d", i / CPB, i % CPB), int'(tx), int'(pat[i / CPB]));
         @(negedge clk);
      end
      chk("t1_busy_end", int'(busy), 0);
      chk("t1_tx_end", int'(tx), 1);
      repeat (5) @(negedge clk);

      // 2: three consecutive pushes, gapless frames
      data = 8'h00; valid = 1'b1; exp_q.push_back(8'h00);
      @(posedge clk); e = cyc;
      @(negedge clk); chk("t2_count_e0", int'(count), 1);
      data = 8'hFF; exp_q.push_back(8'hFF);
      @(negedge clk); chk("t2_count_e1", int'(count), 1);
      data = 8'h41; exp_q.push_back(8'h41);
      @(negedge clk); chk("t2_count_e2", int'(count), 2);
      valid = 1'b0;
      goto_after(e + 160);
      chk("t2_stop1_tx", int'(tx), 1);
      chk("t2_stop1_count", int'(count), 2);
      goto_after(e + 161);
      chk("t2_start2_tx", int'(tx), 0);
      chk("t2_start2_count", int'(count), 1);
      goto_after(e + 320);
      chk("t2_stop2_tx", int'(tx), 1);
      goto_after(e + 321);
      chk("t2_start3_tx", int'(tx), 0);
      chk("t2_start3_count", int'(count), 0);
      goto_after(e + 480);
      chk("t2_busy_last", int'(busy), 1);
      goto_after(e + 481);
      chk("t2_busy_after", int'(busy), 0);
      chk("t2_tx_after", int'(tx), 1);
      repeat (5) @(negedge clk);

      // 3: i_valid held across six bytes, sixth waits for the first STOP pop
      for (int k = 0; k < 5; k++) hold_push(8'hC0 + 8'(k), a[k]);
      chk("t3_ready_full", int'(ready), 0);
      chk("t3_count_full", int'(count), 4);
      hold_push(8'hC5, a[5]);
      valid = 1'b0;
      for (int k = 1; k < 5; k++) chk($sformatf("t3_accept%0d", k), a[k] - a[0], k);
      chk("t3_accept5", a[5] - a[0], 162);
      wait_idle(2000);
      repeat (5) @(negedge clk);

      // 4: asynchronous reset mid-DATA of 0xA3 with two bytes queued
      hold_push(8'hA3, e);
      hold_push(8'h11, a[0]);
      hold_push(8'h22, a[1]);
      valid = 1'b0;
      goto_after(e + 1 + 55);
      chk("t4_tx_bit2_low", int'(tx), 0);
      chk("t4_count_pre", int'(count), 2);
      chk("t4_busy_pre", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      chk("t4_rst_tx", int'(tx), 1);
      chk("t4_rst_count", int'(count), 0);
      chk("t4_rst_busy", int'(busy), 0);
      chk("t4_rst_ready", int'(ready), 1);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lows = 0;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (!tx) lows++;
      end
      chk("t4_line_idle_lows", lows, 0);
      chk("t4_busy_idle", int'(busy), 0);

      // 5: push on the STOP->START pop edge while full is rejected
      for (int k = 0; k < 5; k++) hold_push(8'h10 + 8'(k), a[k]);
      valid = 1'b0;
      goto_after(a[0] + 160);
      chk("t5_ready_full", int'(ready), 0);
      chk("t5_count_full", int'(count), 4);
      data = 8'h99; valid = 1'b1;
      @(negedge clk);
      valid = 1'b0;
      chk("t5_count_after_pop", int'(count), 3);
      chk("t5_ready_after_pop", int'(ready), 1);
      wait_idle(2000);
      repeat (5) @(negedge clk);

      // 6: every byte value through the line
      for (int v = 0; v < 256; v++) hold_push(8'(v), e);
      valid = 1'b0;
      wait_idle(2000);
      repeat (20) @(negedge clk);

      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
